// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and constants for the ctrl_seq sequencer:
//                FSM state encoding, instruction classes, opcode/funct
//                fields and ALU control encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Decoded instruction class; anything unsupported is CLS_ILLEGAL
    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_ADDI    = 2'd1,
        CLS_ADD     = 2'd2,
        CLS_BNE     = 2'd3
    } instr_cls_e;

    // Opcode / funct field values for the supported subset
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [2:0] c_f3_add     = 3'b000;
    localparam logic [2:0] c_f3_bne     = 3'b001;
    localparam logic [6:0] c_f7_add     = 7'b0000000;

    // ALU control encodings
    localparam logic c_aluctrl_add = 1'b0;
    localparam logic c_aluctrl_sub = 1'b1;

    // Classify a 32-bit instruction word into one of the supported classes
    function automatic instr_cls_e classify(input logic [31:0] w);
        instr_cls_e cls;
        cls = CLS_ILLEGAL;
        if (w[6:0] == c_opc_op_imm && w[14:12] == c_f3_add) begin
            cls = CLS_ADDI;
        end else if (w[6:0] == c_opc_op && w[14:12] == c_f3_add &&
                     w[31:25] == c_f7_add) begin
            cls = CLS_ADD;
        end else if (w[6:0] == c_opc_branch && w[14:12] == c_f3_bne) begin
            cls = CLS_BNE;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational immediate generator. Produces the
//                sign-extended I-type immediate for addi, the B-type branch
//                offset for bne, and zero for every other class.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr_i,
    input  instr_cls_e            cls_i,
    output logic [DATA_WIDTH-1:0] imm_o
);

    logic [11:0] w_imm_i;
    logic [12:0] w_imm_b;
    logic        w_unused;

    assign w_imm_i = instr_i[31:20];
    assign w_imm_b = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};

    // Opcode, funct3 and rs1 bits never contribute to an immediate
    assign w_unused = ^{instr_i[19:12], instr_i[6:0]};

    // Select and sign-extend the immediate for the current instruction class
    always_comb begin
        imm_o = '0;
        case (cls_i)
            CLS_ADDI: imm_o = {{(DATA_WIDTH-12){w_imm_i[11]}}, w_imm_i};
            CLS_BNE:  imm_o = {{(DATA_WIDTH-13){w_imm_b[12]}}, w_imm_b};
            default:  imm_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_seq
//  Description : Multicycle control sequencer for the ALU/register-file
//                datapath. Accepts addi/add/bne words over valid/ready,
//                steps them through DECODE/EXEC/WB, owns the PC and halts
//                with a sticky error on any illegal word.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int PC_WIDTH      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    input  logic [31:0]              instr,
    output logic                     instr_ready,
    input  logic                     EQ,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic                     ALUctrl,
    output logic [DATA_WIDTH-1:0]    immOp,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [PC_WIDTH-1:0]      pc,
    output logic                     error
);

    localparam logic [PC_WIDTH-1:0] c_pc_step = PC_WIDTH'(4);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                err_q, err_d;
    logic [31:0]         ir_q, ir_d;

    instr_cls_e          w_cls;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [PC_WIDTH-1:0] w_boff;

    assign w_cls = classify(ir_q);

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .instr_i (ir_q),
        .cls_i   (w_cls),
        .imm_o   (w_imm)
    );

    // Branch offset resized to the PC width, keeping two's-complement sign
    generate
        if (PC_WIDTH <= DATA_WIDTH) begin : g_boff_trunc
            assign w_boff = w_imm[PC_WIDTH-1:0];
        end else begin : g_boff_sext
            assign w_boff = {{(PC_WIDTH-DATA_WIDTH){w_imm[DATA_WIDTH-1]}}, w_imm};
        end
    endgenerate

    // Register fields come straight from the latched instruction word
    assign rs1   = ADDRESS_WIDTH'(ir_q[19:15]);
    assign rs2   = ADDRESS_WIDTH'(ir_q[24:20]);
    assign rd    = ADDRESS_WIDTH'(ir_q[11:7]);
    assign immOp = w_imm;
    assign pc    = pc_q;
    assign error = err_q;

    // State, PC, error flag and instruction register; reset aborts at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            err_q   <= 1'b0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic and Moore control strobes
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        err_d       = err_q;
        ir_d        = ir_q;
        instr_ready = 1'b0;
        RegWrite    = 1'b0;
        ALUsrc      = 1'b0;
        ALUctrl     = c_aluctrl_add;
        case (state_q)
            ST_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_cls == CLS_ILLEGAL) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ALUsrc = (w_cls == CLS_ADDI);
                if (w_cls == CLS_BNE) begin
                    // EQ is the datapath compare of rs1/rs2 during this cycle
                    ALUctrl = c_aluctrl_sub;
                    pc_d    = EQ ? (pc_q + c_pc_step) : (pc_q + w_boff);
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                ALUsrc   = (w_cls == CLS_ADDI);
                // Writes to x0 are dropped at the strobe
                RegWrite = (ir_q[11:7] != 5'd0);
                pc_d     = pc_q + c_pc_step;
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_seq
//  Description : Self-checking bench for ctrl_seq. A transaction model turns
//                every accepted word into its expected per-cycle output
//                trace; a compare process checks the DUT on each falling
//                edge, and directed literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        EQ;
    logic        RegWrite;
    logic        ALUsrc;
    logic        ALUctrl;
    logic [31:0] immOp;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
    logic        error;

    ctrl_seq #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .PC_WIDTH      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .EQ          (EQ),
        .RegWrite    (RegWrite),
        .ALUsrc      (ALUsrc),
        .ALUctrl     (ALUctrl),
        .immOp       (immOp),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .pc          (pc),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle plus the model state it leaves behind
    typedef struct {
        bit          ready;
        bit          rw;
        bit          asrc;
        bit          actl;
        bit          err;
        bit          chk_f;
        bit          nxt_err;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] nxt_pc;
        logic [4:0]  f_rs1;
        logic [4:0]  f_rs2;
        logic [4:0]  f_rd;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pc;
    bit          m_err;
    bit          exp_ready_now;
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.ready = 0; e.rw = 0; e.asrc = 0; e.actl = 0; e.err = 0;
        e.chk_f = 0; e.nxt_err = 0;
        e.pc = '0; e.imm = '0; e.nxt_pc = '0;
        e.f_rs1 = '0; e.f_rs2 = '0; e.f_rd = '0;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc          = '0;
        m_err         = 0;
        exp_ready_now = 1;
    endtask

    // Expand one accepted word into its expected cycle trace
    task automatic model_accept(input logic [31:0] w, input bit eq_v);
        int          kind;
        logic [31:0] imm;
        logic [31:0] p;
        exp_t        d, x, b;
        p = m_pc;
        if (w[6:0] == 7'h13 && w[14:12] == 3'd0)                          kind = 1;
        else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) kind = 2;
        else if (w[6:0] == 7'h63 && w[14:12] == 3'd1)                     kind = 3;
        else                                                               kind = 0;
        if (kind == 1)      imm = {{20{w[31]}}, w[31:20]};
        else if (kind == 3) imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        else                imm = '0;
        d = blank();
        d.pc = p; d.nxt_pc = p; d.chk_f = (kind != 0); d.imm = imm;
        d.f_rs1 = w[19:15]; d.f_rs2 = w[24:20]; d.f_rd = w[11:7];
        d.nxt_err = (kind == 0);
        q.push_back(d);
        if (kind != 0) begin
            x = d;
            x.asrc = (kind == 1);
            x.actl = (kind == 3);
            if (kind == 3) begin
                x.nxt_pc = eq_v ? p + 32'd4 : p + imm;
                q.push_back(x);
            end else begin
                q.push_back(x);
                b = x;
                b.rw = (w[11:7] != 5'd0);
                b.nxt_pc = p + 32'd4;
                q.push_back(b);
            end
        end
    endtask

    // Per-cycle comparison of every DUT output against the model trace
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                end else begin
                    e = blank();
                    e.ready = !m_err; e.err = m_err; e.pc = m_pc;
                    e.nxt_pc = m_pc; e.nxt_err = m_err;
                end
                chk("instr_ready", 32'(instr_ready), 32'(e.ready));
                chk("RegWrite",    32'(RegWrite),    32'(e.rw));
                chk("ALUsrc",      32'(ALUsrc),      32'(e.asrc));
                chk("ALUctrl",     32'(ALUctrl),     32'(e.actl));
                chk("error",       32'(error),       32'(e.err));
                chk("pc",          pc,               e.pc);
                if (e.chk_f) begin
                    chk("immOp", immOp,     e.imm);
                    chk("rs1",   32'(rs1),  32'(e.f_rs1));
                    chk("rs2",   32'(rs2),  32'(e.f_rs2));
                    chk("rd",    32'(rd),   32'(e.f_rd));
                end
                m_pc          = e.nxt_pc;
                m_err         = e.nxt_err;
                exp_ready_now = e.ready;
            end
        end
    end

    // Present a word until the model says it is taken or the bound expires
    task automatic send(input logic [31:0] w, input bit eq_v, input int hold_extra,
                        input int budget, input bit expect_acc, output bit acc);
        @(posedge clk);
        #1;
        instr       = w;
        instr_valid = 1'b1;
        EQ          = eq_v;
        acc         = 0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(posedge clk);
            if (exp_ready_now) begin
                acc = 1;
                model_accept(w, eq_v);
            end
            #1;
        end
        for (int i = 0; i < hold_extra; i++) begin
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        if (expect_acc) chk("accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (q.size() == 0 && exp_ready_now) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL idle_wait: sequencer not back in fetch at %0t", $time);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        bit acc;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        EQ          = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        // Reset values
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_pc",    pc,               32'd0);
        chk("rst_error", 32'(error),       32'd0);
        chk("rst_rw",    32'(RegWrite),    32'd0);
        chk("rst_imm",   immOp,            32'd0);
        chk("rst_rd",    32'(rd),          32'd0);

        // Backpressure: nothing offered for 10 cycles
        repeat (10) @(posedge clk);
        #1;
        chk("idle_pc", pc, 32'd0);

        // addi x1,x0,5
        send(32'h00500093, 1'b0, 0, 20, 1'b1, acc);
        chk("addi_rs1", 32'(rs1), 32'd0);
        chk("addi_rd",  32'(rd),  32'd1);
        chk("addi_imm", immOp,    32'd5);
        wait_idle();
        chk("addi_pc", pc, 32'h4);

        // add x3,x1,x2 with valid held high while busy
        send(32'h002081B3, 1'b0, 3, 20, 1'b1, acc);
        chk("add_rs1", 32'(rs1), 32'd1);
        chk("add_rs2", 32'(rs2), 32'd2);
        chk("add_rd",  32'(rd),  32'd3);
        wait_idle();
        chk("add_pc", pc, 32'h8);

        // addi x0,x0,5: write suppressed, PC still advances
        send(32'h00500013, 1'b0, 0, 20, 1'b1, acc);
        wait_idle();
        chk("x0_pc", pc, 32'hC);

        // addi x2,x0,-1: negative I-immediate
        send(32'hFFF00113, 1'b0, 0, 20, 1'b1, acc);
        chk("neg_imm", immOp, 32'hFFFFFFFF);
        wait_idle();
        chk("pre_bne_pc", pc, 32'h10);

        // bne x1,x2,+8 not equal -> taken
        send(32'h00209463, 1'b0, 0, 20, 1'b1, acc);
        chk("bne_imm", immOp, 32'd8);
        wait_idle();
        chk("bne_taken_pc", pc, 32'h18);

        // bne x1,x2,-8 not equal -> back to 0x10
        send(32'hFE209CE3, 1'b0, 0, 20, 1'b1, acc);
        chk("bne_neg_imm", immOp, 32'hFFFFFFF8);
        wait_idle();
        chk("bne_back_pc", pc, 32'h10);

        // bne x1,x2,+8 equal -> fall through
        send(32'h00209463, 1'b1, 0, 20, 1'b1, acc);
        wait_idle();
        chk("bne_ntaken_pc", pc, 32'h14);

        // Reset asserted in the middle of WB
        send(32'h00500093, 1'b0, 0, 20, 1'b1, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("wb_rw", 32'(RegWrite), 32'd1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_rw",    32'(RegWrite), 32'd0);
        chk("mid_rst_pc",    pc,            32'd0);
        chk("mid_rst_error", 32'(error),    32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(instr_ready), 32'd1);

        // Illegal word halts; later words are ignored
        send(32'hFFFFFFFF, 1'b0, 0, 20, 1'b1, acc);
        repeat (3) @(posedge clk);
        #1;
        chk("halt_error", 32'(error),       32'd1);
        chk("halt_ready", 32'(instr_ready), 32'd0);
        send(32'h00500093, 1'b0, 0, 6, 1'b0, acc);
        repeat (2) @(posedge clk);
        #1;
        chk("halt_pc",     pc,           32'd0);
        chk("halt_sticky", 32'(error),   32'd1);

        // Only reset clears the halt
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("clr_error", 32'(error),       32'd0);
        chk("clr_ready", 32'(instr_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
